// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared colour, state and LFSR constants for the game datapath
package game_pkg;

    localparam logic [1:0] COL_RED    = 2'b00;
    localparam logic [1:0] COL_BLUE   = 2'b01;
    localparam logic [1:0] COL_YELLOW = 2'b10;
    localparam logic [1:0] COL_GREEN  = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    // Right-shifting Galois masks with maximal period for each width
    localparam logic [7:0]  TAPS_8   = 8'hB8;
    localparam logic [7:0]  SEED_8   = 8'h01;
    localparam logic [15:0] TAPS_16  = 16'hB400;
    localparam logic [15:0] SEED_16  = 16'h0001;
    localparam logic [31:0] TAPS_32  = 32'h8020_0003;
    localparam logic [31:0] SEED_32  = 32'h0000_0001;

endpackage

// File: rtl/galois_lfsr.sv
// rtl/galois_lfsr.sv - free-running right-shift Galois LFSR with reseed and zero-lockup guard
module galois_lfsr #(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_RST = 16'h0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_next;
    logic [LFSR_W-1:0] w_seed_safe;

    assign w_next      = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign w_seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

    // An all-zero register would never leave zero, so it is kicked back to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED_RST;
        end else if (load) begin
            r_lfsr <= w_seed_safe;
        end else if (r_lfsr == '0) begin
            r_lfsr <= LFSR_W'(1);
        end else begin
            r_lfsr <= w_next;
        end
    end

    assign state = r_lfsr;

endmodule

// File: rtl/color_seq_gen.sv
// rtl/color_seq_gen.sv - builds a random colour sequence and replays it over a valid/ready stream
module color_seq_gen
    import game_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_RST = 16'h0001,
    parameter int                SYM_W    = 2,
    parameter int                MAX_LEN  = 16,
    parameter int                LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              clear,
    input  logic              append,
    input  logic              replay,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic [SYM_W-1:0]  sym_out,
    output logic              sym_last,
    output logic              done,
    output logic              overflow,
    output logic              busy,
    output logic [LEN_W-1:0]  seq_len,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int               ADDR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_PLAY  = PLAY;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_LEN);

    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_seq_len;
    logic [LEN_W-1:0] r_index;
    logic             r_done;
    logic             r_overflow;
    logic [SYM_W-1:0] r_mem [2**ADDR_W];

    logic [LFSR_W-1:0] w_lfsr;
    logic              w_play;
    logic              w_full;
    logic              w_empty;
    logic              w_last;
    logic              w_write;

    galois_lfsr #(
        .LFSR_W   (LFSR_W),
        .TAPS     (TAPS),
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (seed_load),
        .seed  (seed),
        .state (w_lfsr)
    );

    assign w_play  = (r_state == ST_PLAY);
    assign w_full  = (r_seq_len == FULL_LEN);
    assign w_empty = (r_seq_len == '0);
    assign w_last  = w_play && (r_index == r_seq_len - LEN_W'(1));
    assign w_write = !w_play && !clear && append && !w_full;

    // Symbol storage carries no reset; seq_len alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_seq_len[ADDR_W-1:0]] <= w_lfsr[SYM_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_seq_len  <= '0;
            r_index    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            if (!w_play) begin
                if (clear) begin
                    r_seq_len <= '0;
                end else if (append) begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_seq_len <= r_seq_len + LEN_W'(1);
                    end
                end else if (replay) begin
                    if (w_empty) begin
                        r_done <= 1'b1;
                    end else begin
                        r_index <= '0;
                        r_state <= ST_PLAY;
                    end
                end
            end else if (sym_ready) begin
                r_index <= r_index + LEN_W'(1);
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign sym_valid  = w_play;
    assign busy       = w_play;
    assign sym_last   = w_last;
    assign sym_out    = w_play ? r_mem[r_index[ADDR_W-1:0]] : '0;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign seq_len    = r_seq_len;
    assign lfsr_state = w_lfsr;

endmodule

// File: tb/tb_color_seq_gen.sv
// tb/tb_color_seq_gen.sv - self-checking bench for color_seq_gen against a queue-based reference model
module tb_color_seq_gen;

    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic        clear = 1'b0;
    logic        append = 1'b0;
    logic        replay = 1'b0;
    logic        sym_ready = 1'b0;
    logic        sym_valid, sym_last, done, overflow, busy;
    logic [1:0]  sym_out;
    logic [4:0]  seq_len;
    logic [15:0] lfsr_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    color_seq_gen dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .clear      (clear),
        .append     (append),
        .replay     (replay),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_out    (sym_out),
        .sym_last   (sym_last),
        .done       (done),
        .overflow   (overflow),
        .busy       (busy),
        .seq_len    (seq_len),
        .lfsr_state (lfsr_state)
    );

    // Reference model: the buffer is a queue, playback is a cursor into it
    logic [15:0] m_lfsr = 16'h0001;
    logic [15:0] m_cur;
    logic [1:0]  m_q[$];
    bit          m_play = 1'b0;
    int          m_idx = 0;
    bit          m_done = 1'b0;
    bit          m_ovf = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr = 16'h0001;
            m_q.delete();
            m_play = 1'b0;
            m_idx  = 0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_cur  = m_lfsr;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            if (!m_play) begin
                if (clear) m_q.delete();
                else if (append) begin
                    if (m_q.size() < 16) m_q.push_back(m_cur[1:0]);
                    else m_ovf = 1'b1;
                end else if (replay) begin
                    if (m_q.size() > 0) begin m_play = 1'b1; m_idx = 0; end
                    else m_done = 1'b1;
                end
            end else if (sym_ready) begin
                m_idx++;
                if (m_idx == m_q.size()) begin m_play = 1'b0; m_done = 1'b1; end
            end
            if (seed_load) m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
            else if (m_cur == 16'h0) m_lfsr = 16'h0001;
            else if (m_cur[0]) m_lfsr = (m_cur >> 1) ^ TAPS;
            else m_lfsr = m_cur >> 1;
        end
    end

    function automatic logic [1:0] m_sym();
        return (m_play && m_idx < m_q.size()) ? m_q[m_idx] : 2'b00;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] walk [12];
        walk = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0,
                 16'h02D0, 16'h0168, 16'h00B4, 16'h005A, 16'h002D, 16'hB416};
        tick(); reset = 1'b0; tick();
        append = 1'b1; repeat (3) tick(); append = 1'b0;
        replay = 1'b1; tick(); replay = 1'b0; tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", busy); end
        reset = 1'b1; #1;
        checks++; if (busy !== 1'b0 || sym_valid !== 1'b0 || sym_last !== 1'b0 || sym_out !== 2'b00)
            begin errors++; $display("FAIL reset_play_outs got busy=%b valid=%b last=%b out=%b exp 0", busy, sym_valid, sym_last, sym_out); end
        checks++; if (seq_len !== 5'd0) begin errors++; $display("FAIL reset_seq_len got %0d exp 0", seq_len); end
        tick(); reset = 1'b0;
        checks++; if (lfsr_state !== 16'h0001) begin errors++; $display("FAIL reset_lfsr got %h exp 0001", lfsr_state); end
        checks++; if (done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%b ovf=%b exp 0", done, overflow); end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++; if (lfsr_state !== walk[k]) begin errors++; $display("FAIL lfsr_walk step %0d got %h exp %h", k + 1, lfsr_state, walk[k]); end
        end
    endtask

    task automatic test_seed();
        seed_load = 1'b1; seed = 16'h0000; tick();
        checks++; if (lfsr_state !== 16'h0001) begin errors++; $display("FAIL seed_zero got %h exp 0001", lfsr_state); end
        seed = 16'hACE1; tick();
        checks++; if (lfsr_state !== 16'hACE1) begin errors++; $display("FAIL seed_ace1 got %h exp ace1", lfsr_state); end
        seed_load = 1'b0; tick();
        checks++; if (lfsr_state !== 16'hE270) begin errors++; $display("FAIL seed_advance got %h exp e270", lfsr_state); end
    endtask

    task automatic test_build_replay();
        logic [1:0] exp_syms [4];
        exp_syms = '{2'b01, 2'b00, 2'b00, 2'b00};
        clear = 1'b1; tick(); clear = 1'b0;
        seed_load = 1'b1; seed = 16'h0001; tick(); seed_load = 1'b0;
        append = 1'b1; repeat (4) tick(); append = 1'b0;
        checks++; if (seq_len !== 5'd4) begin errors++; $display("FAIL build_len got %0d exp 4", seq_len); end
        sym_ready = 1'b1; replay = 1'b1; tick(); replay = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (sym_valid !== 1'b1 || sym_out !== exp_syms[i] || sym_last !== (i == 3))
                begin errors++; $display("FAIL replay_sym %0d got v=%b out=%b last=%b exp v=1 out=%b last=%b", i, sym_valid, sym_out, sym_last, exp_syms[i], (i == 3)); end
            tick();
        end
        checks++; if (done !== 1'b1 || sym_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL replay_done got done=%b v=%b busy=%b exp 1 0 0", done, sym_valid, busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL replay_done_width got %b exp 0", done); end
    endtask

    task automatic test_backpressure();
        logic       pat [5];
        logic [1:0] prev;
        int         xfers;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        xfers = 0;
        prev = 2'b00;
        clear = 1'b1; tick(); clear = 1'b0;
        append = 1'b1; repeat (3) tick(); append = 1'b0;
        sym_ready = 1'b0; replay = 1'b1; tick(); replay = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (busy !== 1'b1 || sym_valid !== 1'b1 || sym_out !== m_sym() || sym_last !== (i == 4))
                begin errors++; $display("FAIL bp_cycle %0d got busy=%b v=%b out=%b last=%b exp 1 1 %b %b", i, busy, sym_valid, sym_out, sym_last, m_sym(), (i == 4)); end
            if (i > 0 && !pat[i-1]) begin
                checks++; if (sym_out !== prev) begin errors++; $display("FAIL bp_hold %0d got %b exp %b", i, sym_out, prev); end
            end
            prev = sym_out;
            sym_ready = pat[i];
            if (sym_valid && sym_ready) xfers++;
            tick();
        end
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL bp_end got busy=%b done=%b exp 0 1", busy, done); end
        checks++; if (xfers !== 3) begin errors++; $display("FAIL bp_xfers got %0d exp 3", xfers); end
    endtask

    task automatic test_full_overflow();
        clear = 1'b1; tick(); clear = 1'b0;
        append = 1'b1; repeat (16) tick();
        checks++; if (seq_len !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL full_len got len=%0d ovf=%b exp 16 0", seq_len, overflow); end
        tick();
        checks++; if (overflow !== 1'b1 || seq_len !== 5'd16) begin errors++; $display("FAIL overflow_pulse got ovf=%b len=%0d exp 1 16", overflow, seq_len); end
        append = 1'b0; tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_width got %b exp 0", overflow); end
        clear = 1'b1; append = 1'b1; tick(); clear = 1'b0; append = 1'b0;
        checks++; if (seq_len !== 5'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clear_wins got len=%0d ovf=%b exp 0 0", seq_len, overflow); end
    endtask

    task automatic test_ignored();
        logic [1:0] snap [2];
        clear = 1'b1; tick(); clear = 1'b0;
        append = 1'b1; repeat (2) tick(); append = 1'b0;
        snap[0] = m_q[0]; snap[1] = m_q[1];
        sym_ready = 1'b0; replay = 1'b1; tick(); replay = 1'b0;
        append = 1'b1; clear = 1'b1; repeat (2) tick(); append = 1'b0; clear = 1'b0;
        checks++; if (seq_len !== 5'd2 || sym_valid !== 1'b1 || sym_out !== snap[0])
            begin errors++; $display("FAIL play_ignores got len=%0d v=%b out=%b exp 2 1 %b", seq_len, sym_valid, sym_out, snap[0]); end
        sym_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (sym_out !== snap[i]) begin errors++; $display("FAIL play_data %0d got %b exp %b", i, sym_out, snap[i]); end
            tick();
        end
        checks++; if (done !== 1'b1 || seq_len !== 5'd2) begin errors++; $display("FAIL play_end got done=%b len=%0d exp 1 2", done, seq_len); end
        clear = 1'b1; tick(); clear = 1'b0;
        replay = 1'b1; tick(); replay = 1'b0;
        checks++; if (done !== 1'b1 || sym_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL empty_replay got done=%b v=%b busy=%b exp 1 0 0", done, sym_valid, busy); end
        tick();
        checks++; if (done !== 1'b0 || sym_valid !== 1'b0) begin errors++; $display("FAIL empty_replay_after got done=%b v=%b exp 0 0", done, sym_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            clear     = ($urandom_range(0, 99) < 5);
            append    = ($urandom_range(0, 99) < 40);
            replay    = ($urandom_range(0, 99) < 15);
            sym_ready = ($urandom_range(0, 99) < 60);
            seed_load = ($urandom_range(0, 99) < 3);
            seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            tick();
            checks++; if (lfsr_state !== m_lfsr) begin errors++; $display("FAIL rnd_lfsr %0d got %h exp %h", n, lfsr_state, m_lfsr); end
            checks++; if (seq_len !== 5'(m_q.size())) begin errors++; $display("FAIL rnd_len %0d got %0d exp %0d", n, seq_len, m_q.size()); end
            checks++; if (sym_valid !== m_play || busy !== m_play || sym_out !== m_sym()
                          || sym_last !== (m_play && m_idx == m_q.size() - 1))
                begin errors++; $display("FAIL rnd_stream %0d got v=%b busy=%b out=%b last=%b exp v=%b out=%b", n, sym_valid, busy, sym_out, sym_last, m_play, m_sym()); end
            checks++; if (done !== m_done || overflow !== m_ovf) begin errors++; $display("FAIL rnd_pulses %0d got done=%b ovf=%b exp %b %b", n, done, overflow, m_done, m_ovf); end
        end
        clear = 1'b0; append = 1'b0; replay = 1'b0; seed_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seed();
        test_build_replay();
        test_backpressure();
        test_full_overflow();
        test_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_seq_gen.md
Name: color_seq_gen

Overview:
- Parametrised pseudo-random colour-sequence generator for the Simon-style game datapath.
- Contains a free-running Galois LFSR with configurable width, taps and seed. The LFSR can be reseeded at run time and cannot lock up in the all-zero state.
- Appends one random SYM_W-bit colour per command into an internal sequence buffer.
- Replays the stored sequence over a valid/ready stream for display and compare logic.

Parameters:
- LFSR_W, 16, LFSR register width (>= SYM_W, >= 3)
- TAPS, 16'hB400, Galois feedback mask (maximal-length for 16 bits)
- SEED_RST, 16'h0001, LFSR value at reset; must be non-zero
- SYM_W, 2, colour symbol width (2 -> red/blue/yellow/green)
- MAX_LEN, 16, sequence buffer depth in symbols
- LEN_W, $clog2(MAX_LEN+1), width of the length/index counters

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- seed_load  in  1  load seed into LFSR next edge
- seed  in  LFSR_W  seed value
- clear  in  1  empty the sequence buffer
- append  in  1  store one random symbol at the tail
- replay  in  1  start streaming the stored sequence
- sym_valid  out  1  sym_out valid (PLAY only)
- sym_ready  in  1  consumer accepts sym_out
- sym_out  out  SYM_W  current replay symbol
- sym_last  out  1  sym_out is the final symbol
- done  out  1  one-cycle pulse: replay finished
- overflow  out  1  one-cycle pulse: append while full
- busy  out  1  high in PLAY
- seq_len  out  LEN_W  symbols stored
- lfsr_state  out  LFSR_W  LFSR register (debug/entropy)

Behaviour:
- Single clock domain. reset is asynchronous, active-high, and applies to every flop except the symbol array.
- Reset values:
  - lfsr = SEED_RST, state = IDLE, seq_len = 0, index = 0.
  - sym_valid, sym_last, done, overflow, busy all = 0; sym_out = 0.
- LFSR:
  - Advances every cycle out of reset, in every state.
  - Next value: if lfsr[0] is 1, (lfsr>>1)^TAPS; otherwise lfsr>>1.
  - seed_load has priority over advance, and is honoured in any state. The next value is the seed, or 1 if the seed is 0.
  - If the register is ever 0, it is forced to 1 on the next edge.
- FSM has two states, IDLE and PLAY.
- IDLE command priority: clear > append > replay; lower-priority commands in the same cycle are ignored.
  - clear: seq_len <= 0.
  - append, seq_len < MAX_LEN: mem[seq_len] <= lfsr[SYM_W-1:0], sampling the current register value before that edge's update; seq_len++.
  - append, seq_len == MAX_LEN: buffer unchanged; overflow pulses for 1 cycle on the next cycle.
  - replay, seq_len > 0: index <= 0; go to PLAY.
  - replay, seq_len == 0: stay IDLE; done pulses on the next cycle.
- PLAY:
  - sym_valid = 1, sym_out = mem[index] and busy = 1, all combinational from state/index.
  - sym_last = (index == seq_len-1).
  - On sym_valid && sym_ready: index++. If sym_last was set, return to IDLE and pulse done on the next cycle.
  - sym_out is held stable while sym_ready is low. There is no timeout.
  - clear/append/replay are ignored in PLAY; the buffer is never modified during replay.
- Throughput: 1 symbol/cycle with sym_ready held high. Latency from replay to first sym_valid is 1 cycle.
- Reset mid-PLAY: return to IDLE immediately; seq_len = 0; stored symbols are discarded.
- The stored sequence persists across replays until clear or reset.

Decomposition:
- Shared package (game_pkg):
  - colour encodings RED=2'b00, BLUE=2'b01, YELLOW=2'b10, GREEN=2'b11
  - state enum {IDLE, PLAY}
  - default TAPS/SEED constants for 8/16/32-bit widths
- One sub-module: galois_lfsr (params LFSR_W, TAPS, SEED_RST; ports clk, reset, load, seed, state). It holds the zero-lockup guard and is reusable by other game blocks.
- Sequence buffer and FSM stay in color_seq_gen.

Test Plan:
- Reset mid-stream, then release: lfsr_state = 0x0001, seq_len = 0, all status outputs 0. Following cycles give 0xB400, 0x5A00, 0x2D00, 0x1680; after 12 steps the value is 0xB416.
- seed_load with seed = 0x0000 -> next lfsr_state = 0x0001 (lockup guard). seed_load with seed = 0xACE1 -> next value = 0xACE1.
- Sequence build and replay:
  - seed_load 0x0001 at t, then append at t+1..t+4 -> seq_len = 4, stored symbols 01,00,00,00.
  - replay with sym_ready = 1 -> sym_out 01,00,00,00 on 4 consecutive cycles, sym_last on the 4th, done pulse 1 cycle later.
- Backpressure: seq_len = 3, replay, sym_ready toggled 1,0,0,1,1 -> sym_out holds during the stalls; exactly 3 transfers; busy high until the final transfer.
- Full and overflow: 16 appends give seq_len = 16. A 17th append -> overflow pulse, seq_len stays 16. clear together with append -> seq_len = 0, no overflow.
- Ignored commands:
  - append/clear during PLAY -> no change to seq_len or to the replayed data.
  - replay with seq_len = 0 -> done pulse only; sym_valid stays 0.
